fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch stage between instruction memory and the IF/ID pipeline register.
- Sequences fetch addresses and buffers fetched instructions, each tagged with its return PC (address+1), in a small FIFO.
- Instructions are presented to IF/ID under a valid/consume handshake driven by the stall signal.
- A one-cycle redirect from decode (jump, branch, return) flushes the queue and restarts fetch at the new target.

Parameters:
- PC_W, 12, program counter / instruction memory address width.
- INSTR_W, 19, instruction word width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  level; leaves IDLE when sampled high.
- imem_addr  output  PC_W  instruction memory read address (= fetch PC).
- imem_rdata  input  INSTR_W  combinational read data for imem_addr, same cycle.
- redirect  input  1  flush-and-redirect pulse from decode.
- redirect_pc  input  PC_W  new fetch target, valid with redirect.
- deq  input  1  consumer takes head this cycle (driven by ~sstall).
- out_valid  output  1  head entry valid.
- out_instr  output  INSTR_W  head instruction; 0 when out_valid=0.
- out_pc  output  PC_W  head return PC (fetch address+1); 0 when out_valid=0.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, async): state=IDLE, fetch PC=0, rd/wr pointers=0, count=0, out_valid=0, out_instr=0, out_pc=0, imem_addr=0.
- FSM IDLE: no push; start=1 at an edge -> RUN.
- FSM RUN: remains RUN until reset; there is no return to IDLE.
- pop = deq & out_valid & ~redirect. deq while empty is ignored.
- push = (state==RUN) & ~redirect & (count<DEPTH | pop). Push while full is allowed only when a pop occurs in the same cycle.
- On push:
  - entry = {imem_rdata, fpc+1}, with fpc+1 modulo 2^PC_W (4095+1 -> 0).
  - fpc <= fpc+1 (same wrap).
- count update: count += push - pop. Pointers wrap modulo DEPTH.
- Latency:
  - Entry pushed at edge N is visible at the head after edge N (out_valid high in cycle N+1).
  - Fetch-to-output latency is 1 cycle.
  - start sampled at E0 -> address 0 fetched in the cycle after E0 -> out_valid after E1.
- Redirect (priority over push and pop):
  - All entries discarded; count <= 0; pointers <= 0.
  - fpc <= redirect_pc.
  - imem_rdata in the redirect cycle is dropped.
  - out_valid=0 in the next cycle.
  - Fetch at redirect_pc occurs in the next cycle; its entry is valid one cycle later.
- Redirect in IDLE: fpc <= redirect_pc; state unchanged.
- Outputs are registered head values; out_instr/out_pc are masked to 0 when empty.
- Reset mid-operation: queue contents discarded immediately; the bench must see no valid entry until start is reasserted.

Decomposition:
- Shared package: PC_W, INSTR_W, DEPTH defaults; fetch FSM state enum {IDLE, RUN}; entry struct {instr, ret_pc}.
- One sub-module: fq_fifo, a generic DEPTH x (INSTR_W+PC_W) synchronous FIFO with push, pop, flush, count, and async active-low reset.
- Fetch PC, FSM, and push/pop/redirect arbitration live in fetch_queue.

Test Plan:
- Startup fill: reset, start=1, deq=0, imem_rdata = 19'h100|addr.
  - After 4 fetches count=4, imem_addr holds at 4.
  - out_instr=19'h100, out_pc=12'h001.
- Streaming: deq=1 continuously after fill.
  - One entry per cycle with out_pc 1,2,3,..., count constant at 4.
  - No gaps or duplicates over 20 cycles.
- Full with simultaneous push/pop: count=4, deq=1 for one cycle.
  - Head advances to out_pc=2, fpc advances by 1, count stays 4.
- Redirect: queue full, pulse redirect with redirect_pc=12'h0A0, deq=1 same cycle.
  - Next cycle out_valid=0, count=0, imem_addr=12'h0A0.
  - Following cycle out_pc=12'h0A1.
- Wrap-around: redirect_pc=12'hFFE.
  - Queue outputs return PCs 12'hFFF, 12'h000, 12'h001 in order.
  - Fetch addresses 12'hFFE, 12'hFFF, 12'h000.
- Async reset mid-stream: drop rst between clock edges with count=3.
  - Outputs go to 0 immediately; after release with start=0, nothing is fetched.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared types and default sizing for the instruction prefetch queue.
// Entries pair a fetched instruction with the return PC of its fetch address.
package fetch_queue_pkg;

  localparam int PC_W    = 12;
  localparam int INSTR_W = 19;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fq_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    ret_pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundles the instruction-memory port, the decode redirect, and the IF/ID handshake.
// The queue sits on the slave side; decode, memory and the bench drive the master side.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               deq;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [CNT_W-1:0]   count;

  modport slave (
    input  imem_rdata, redirect, redirect_pc, deq,
    output imem_addr, out_valid, out_instr, out_pc, count
  );

  modport master (
    output imem_rdata, redirect, redirect_pc, deq,
    input  imem_addr, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO with flush; the head word reads as zero when empty.
// Callers must not push into a full FIFO unless they pop in the same cycle.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: walks the fetch PC through instruction memory and buffers
// {instr, PC+1} entries for IF/ID; a decode redirect flushes and retargets fetch.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  fetch_queue_if.slave   bus
);
  fq_state_e        state_q;
  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic             push, pop;
  logic [CNT_W-1:0] cnt;
  fq_entry_t        wr_entry, rd_entry;

  // Redirect outranks both sides; a full queue still accepts when its head leaves.
  assign pop  = bus.deq & bus.out_valid & ~bus.redirect;
  assign push = (state_q == RUN) & ~bus.redirect & ((cnt < CNT_W'(DEPTH)) | pop);

  always_comb begin
    fpc_d = fpc_q;
    if (bus.redirect)  fpc_d = bus.redirect_pc;
    else if (push)     fpc_d = fpc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fpc_q   <= '0;
    end else begin
      fpc_q <= fpc_d;
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_entry.instr  = bus.imem_rdata;
  assign wr_entry.ret_pc = fpc_q + 1'b1;

  fq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (wr_entry),
    .dout  (rd_entry),
    .count (cnt)
  );

  assign bus.imem_addr = fpc_q;
  assign bus.out_valid = (cnt != '0);
  assign bus.out_instr = rd_entry.instr;
  assign bus.out_pc    = rd_entry.ret_pc;
  assign bus.count     = cnt;

endmodule
